// File: rtl/arcade_menu_nav.sv
// Menu/session controller: wrap-around game selection with typematic repeat,
// center-press launch, registered button forwarding and long-hold exit.
module arcade_menu_nav #(
  parameter int NUM_GAMES    = 4,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int EXIT_HOLD    = 100_000_000,
  parameter int IDX_W        = $clog2(NUM_GAMES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       btn_pulse,
  input  logic [4:0]       btn_level,
  output logic [IDX_W-1:0] sel_idx,
  output logic             game_active,
  output logic             game_start,
  output logic             game_exit,
  output logic [4:0]       game_btn_pulse,
  output logic [4:0]       game_btn_level,
  output logic             dbg_state
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int EXIT_W  = $clog2(EXIT_HOLD);

  localparam logic [IDX_W-1:0]  SEL_LAST  = IDX_W'(NUM_GAMES - 1);
  localparam logic [REP_W-1:0]  REP_DLY   = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0]  REP_RT    = REP_W'(REPEAT_RATE);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [EXIT_W-1:0] EXIT_LAST = EXIT_W'(EXIT_HOLD - 1);
  localparam logic [EXIT_W-1:0] EXIT_ONE  = EXIT_W'(1);

  typedef enum logic {MENU = 1'b0, PLAY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d, sel_prev, sel_next;
  logic              rep_arm_q, rep_arm_d;
  logic              rep_dir_q, rep_dir_d;     // 1 = down, 0 = up
  logic              rep_first_q, rep_first_d; // waiting for the initial delay
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d, rep_tgt;
  logic              rep_hold;
  logic              exit_arm_q, exit_arm_d;
  logic [EXIT_W-1:0] exit_cnt_q, exit_cnt_d;
  logic              mask_q, mask_d;
  logic              launch, do_exit, fwd;
  logic              up_p, down_p;
  logic [4:0]        gbp_d, gbl_d;

  assign up_p     = btn_pulse[0];
  assign down_p   = btn_pulse[1];
  assign sel_prev = (sel_q == '0) ? SEL_LAST : sel_q - IDX_W'(1);
  assign sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + IDX_W'(1);
  assign rep_tgt  = rep_first_q ? REP_DLY : REP_RT;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rep_arm_d   = rep_arm_q;
    rep_dir_d   = rep_dir_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    exit_arm_d  = exit_arm_q;
    exit_cnt_d  = exit_cnt_q;
    mask_d      = mask_q;
    launch      = 1'b0;
    do_exit     = 1'b0;
    rep_hold    = rep_dir_q ? (btn_level[1] & ~btn_level[0])
                            : (btn_level[0] & ~btn_level[1]);
    case (state_q)
      MENU: begin
        exit_arm_d = 1'b0;
        exit_cnt_d = '0;
        if (btn_pulse[4]) begin
          // Center wins over any simultaneous up/down: launch current index.
          state_d     = PLAY;
          launch      = 1'b1;
          mask_d      = 1'b1;
          rep_arm_d   = 1'b0;
          rep_first_d = 1'b0;
          rep_cnt_d   = '0;
        end else if (up_p ^ down_p) begin
          sel_d       = up_p ? sel_prev : sel_next;
          rep_arm_d   = 1'b1;
          rep_dir_d   = down_p;
          rep_first_d = 1'b1;
          rep_cnt_d   = REP_ONE;
        end else if (rep_arm_q) begin
          if (!rep_hold) begin
            rep_arm_d   = 1'b0;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
          end else if (rep_cnt_q == rep_tgt) begin
            sel_d       = rep_dir_q ? sel_next : sel_prev;
            rep_first_d = 1'b0;
            rep_cnt_d   = REP_ONE;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
          end
        end
      end
      PLAY: begin
        rep_arm_d   = 1'b0;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
        if (!btn_level[4]) mask_d = 1'b0;
        if (btn_pulse[4]) begin
          exit_arm_d = 1'b1;
          exit_cnt_d = EXIT_ONE;
        end else if (exit_arm_q) begin
          if (!btn_level[4]) begin
            exit_arm_d = 1'b0;
            exit_cnt_d = '0;
          end else if (exit_cnt_q == EXIT_LAST) begin
            // This cycle is the EXIT_HOLD-th consecutive held cycle.
            state_d    = MENU;
            do_exit    = 1'b1;
            exit_arm_d = 1'b0;
            exit_cnt_d = '0;
            mask_d     = 1'b0;
          end else begin
            exit_cnt_d = exit_cnt_q + EXIT_ONE;
          end
        end
      end
      default: state_d = MENU;
    endcase
  end

  // Forward only while both the sampling cycle and the next are in PLAY, so
  // neither the launch pulse nor the exiting hold reaches the game.
  always_comb begin
    fwd   = (state_q == PLAY) && (state_d == PLAY);
    gbp_d = fwd ? btn_pulse : 5'b0;
    gbl_d = fwd ? {btn_level[4] & ~mask_q, btn_level[3:0]} : 5'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MENU;
      sel_q          <= '0;
      rep_arm_q      <= 1'b0;
      rep_dir_q      <= 1'b0;
      rep_first_q    <= 1'b0;
      rep_cnt_q      <= '0;
      exit_arm_q     <= 1'b0;
      exit_cnt_q     <= '0;
      mask_q         <= 1'b0;
      game_active    <= 1'b0;
      game_start     <= 1'b0;
      game_exit      <= 1'b0;
      game_btn_pulse <= 5'b0;
      game_btn_level <= 5'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      rep_arm_q      <= rep_arm_d;
      rep_dir_q      <= rep_dir_d;
      rep_first_q    <= rep_first_d;
      rep_cnt_q      <= rep_cnt_d;
      exit_arm_q     <= exit_arm_d;
      exit_cnt_q     <= exit_cnt_d;
      mask_q         <= mask_d;
      game_active    <= (state_d == PLAY);
      game_start     <= launch;
      game_exit      <= do_exit;
      game_btn_pulse <= gbp_d;
      game_btn_level <= gbl_d;
    end
  end

  assign sel_idx   = sel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arcade_menu_nav.sv
// Bench for arcade_menu_nav: per-cycle expected outputs queued at drive time
// and compared one edge later.
module tb_arcade_menu_nav;

  localparam int NG = 3;
  localparam logic [4:0] Z = 5'b00000;
  localparam logic [4:0] U = 5'b00001;
  localparam logic [4:0] D = 5'b00010;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] R = 5'b01000;
  localparam logic [4:0] C = 5'b10000;

  logic       clk;
  logic       rst;
  logic [4:0] btn_pulse, btn_level;
  logic [1:0] sel_idx;
  logic       game_active, game_start, game_exit, dbg_state;
  logic [4:0] game_btn_pulse, game_btn_level;

  arcade_menu_nav #(
    .NUM_GAMES(NG), .REPEAT_DELAY(8), .REPEAT_RATE(3), .EXIT_HOLD(10)
  ) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .btn_level(btn_level),
    .sel_idx(sel_idx), .game_active(game_active), .game_start(game_start),
    .game_exit(game_exit), .game_btn_pulse(game_btn_pulse),
    .game_btn_level(game_btn_level), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {state, sel, active, start, exit, gp, gl}
  logic [15:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic        r;
    logic [4:0]  p;
    logic [4:0]  l;
    logic [15:0] e;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [15:0] ex(input logic [1:0] sel, input logic act,
                                     input logic st, input logic ext,
                                     input logic [4:0] gp, input logic [4:0] gl);
    return {act, sel, act, st, ext, gp, gl};
  endfunction

  task automatic check();
    logic [15:0] got, exp;
    string nm;
    got = {dbg_state, sel_idx, game_active, game_start, game_exit,
           game_btn_pulse, game_btn_level};
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%b sel=%0d act=%b start=%b exit=%b gp=%b gl=%b, expected st=%b sel=%0d act=%b start=%b exit=%b gp=%b gl=%b",
               nm, got[15], got[14:13], got[12], got[11], got[10], got[9:5], got[4:0],
               exp[15], exp[14:13], exp[12], exp[11], exp[10], exp[9:5], exp[4:0]);
    end
  endtask

  // driver
  task automatic cyc(input logic r, input logic [4:0] p, input logic [4:0] l,
                     input logic [15:0] e, input string nm);
    @(negedge clk);
    rst       = r;
    btn_pulse = p;
    btn_level = l;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check();
  endtask

  function automatic void add(input logic r, input logic [4:0] p, input logic [4:0] l,
                              input logic [15:0] e, input string nm);
    vec_t v;
    v.r = r; v.p = p; v.l = l; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [1:0] s;
    rst = 1'b1; btn_pulse = Z; btn_level = Z;

    // reset, manual steps, simultaneous events
    add(1, Z, Z, ex(0, 0, 0, 0, Z, Z), "reset0");
    add(1, Z, Z, ex(0, 0, 0, 0, Z, Z), "reset1");
    add(0, Z, Z, ex(0, 0, 0, 0, Z, Z), "idle_after_reset");
    add(0, D, D, ex(1, 0, 0, 0, Z, Z), "down_1");
    add(0, Z, Z, ex(1, 0, 0, 0, Z, Z), "idle_1");
    add(0, D, D, ex(2, 0, 0, 0, Z, Z), "down_2");
    add(0, Z, Z, ex(2, 0, 0, 0, Z, Z), "idle_2");
    add(0, D, D, ex(0, 0, 0, 0, Z, Z), "down_wrap_0");
    add(0, Z, Z, ex(0, 0, 0, 0, Z, Z), "idle_0");
    add(0, U, U, ex(2, 0, 0, 0, Z, Z), "up_wrap_2");
    add(0, Z, Z, ex(2, 0, 0, 0, Z, Z), "idle_2b");
    add(0, D, D, ex(0, 0, 0, 0, Z, Z), "down_to_0");
    add(0, Z, Z, ex(0, 0, 0, 0, Z, Z), "idle_0b");
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].r, tbl[i].p, tbl[i].l, tbl[i].e, tbl[i].nm);

    // auto-repeat: steps at T, T+8, T+11, T+14
    cyc(0, D, D, ex(1, 0, 0, 0, Z, Z), "rep_k0");
    for (int k = 1; k <= 14; k++) begin
      s = (k < 8) ? 2'd1 : (k < 11) ? 2'd2 : (k < 14) ? 2'd0 : 2'd1;
      cyc(0, Z, D, ex(s, 0, 0, 0, Z, Z), $sformatf("rep_k%0d", k));
    end
    for (int k = 15; k <= 20; k++)
      cyc(0, Z, Z, ex(1, 0, 0, 0, Z, Z), $sformatf("rep_rel_k%0d", k));

    tbl.delete();
    add(0, U | D, U | D, ex(1, 0, 0, 0, Z, Z), "up_down_same");
    add(0, Z, U | D, ex(1, 0, 0, 0, Z, Z), "up_down_held");
    add(0, Z, Z, ex(1, 0, 0, 0, Z, Z), "idle_1c");
    add(0, C | D, C | D, ex(1, 1, 1, 0, Z, Z), "center_down_launch");
    add(0, Z, Z, ex(1, 1, 0, 0, Z, Z), "play_idle");
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].r, tbl[i].p, tbl[i].l, tbl[i].e, tbl[i].nm);

    // exit from sel 1, then a held center after exit does nothing
    cyc(0, C, C, ex(1, 1, 0, 0, C, C), "exitA_k0");
    for (int k = 1; k <= 8; k++) cyc(0, Z, C, ex(1, 1, 0, 0, Z, C), $sformatf("exitA_k%0d", k));
    cyc(0, Z, C, ex(1, 0, 0, 1, Z, Z), "exitA_k9");
    cyc(0, Z, C, ex(1, 0, 0, 0, Z, Z), "exitA_held1");
    cyc(0, Z, C, ex(1, 0, 0, 0, Z, Z), "exitA_held2");
    cyc(0, Z, Z, ex(1, 0, 0, 0, Z, Z), "exitA_rel");
    cyc(0, D, D, ex(2, 0, 0, 0, Z, Z), "down_to_2");
    cyc(0, Z, Z, ex(2, 0, 0, 0, Z, Z), "idle_2c");

    // launch masking: center held 30 cycles from launch
    cyc(0, C, C, ex(2, 1, 1, 0, Z, Z), "mask_launch");
    for (int k = 1; k < 30; k++) cyc(0, Z, C, ex(2, 1, 0, 0, Z, Z), $sformatf("mask_k%0d", k));
    cyc(0, Z, Z, ex(2, 1, 0, 0, Z, Z), "mask_rel");

    // forwarding
    cyc(0, R, R, ex(2, 1, 0, 0, R, R), "fwd_right");
    cyc(0, Z, Z, ex(2, 1, 0, 0, Z, Z), "fwd_right_gone");

    // 9-cycle hold: no exit
    cyc(0, C, C, ex(2, 1, 0, 0, C, C), "hold9_k0");
    for (int k = 1; k <= 8; k++) cyc(0, Z, C, ex(2, 1, 0, 0, Z, C), $sformatf("hold9_k%0d", k));
    cyc(0, Z, Z, ex(2, 1, 0, 0, Z, Z), "hold9_rel");
    cyc(0, Z, Z, ex(2, 1, 0, 0, Z, Z), "hold9_idle");

    // 10-cycle hold: exit in P+10
    cyc(0, C, C, ex(2, 1, 0, 0, C, C), "hold10_k0");
    for (int k = 1; k <= 8; k++) cyc(0, Z, C, ex(2, 1, 0, 0, Z, C), $sformatf("hold10_k%0d", k));
    cyc(0, Z, C, ex(2, 0, 0, 1, Z, Z), "hold10_exit");
    cyc(0, Z, Z, ex(2, 0, 0, 0, Z, Z), "hold10_after");

    // reset in PLAY
    cyc(0, C, C, ex(2, 1, 1, 0, Z, Z), "rst_launch");
    cyc(0, Z, Z, ex(2, 1, 0, 0, Z, Z), "rst_play_idle");
    cyc(0, Z, L, ex(2, 1, 0, 0, Z, L), "rst_play_left");
    cyc(1, R, R | L, ex(0, 0, 0, 0, Z, Z), "rst_mid_play");
    cyc(0, Z, Z, ex(0, 0, 0, 0, Z, Z), "rst_released");
    cyc(0, D, D, ex(1, 0, 0, 0, Z, Z), "post_rst_down");
    cyc(0, Z, Z, ex(1, 0, 0, 0, Z, Z), "post_rst_idle");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arcade_menu_nav.md
# arcade_menu_nav

Game-select and session controller for the Vericade Logic Lab Arcade, sitting directly downstream of the button debouncer. It consumes the debounced `btn_pulse` and `btn_level` vectors, runs the menu with up/down wrap-around selection and typematic auto-repeat, and launches the selected game on a center press. While a game runs, it forwards buttons to the game logic, and a long center hold exits back to the menu.

## Interface
- `NUM_GAMES`, default 4: number of selectable games, must be ≥2.
- `REPEAT_DELAY`, default 25_000_000: hold cycles from the initial press to the first auto-repeat step (500 ms at 50 MHz), must be ≥1.
- `REPEAT_RATE`, default 5_000_000: cycles between subsequent auto-repeat steps, must be ≥1.
- `EXIT_HOLD`, default 100_000_000: center-hold cycles in PLAY that force an exit to the menu, must be ≥2.
- `IDX_W`, derived: $clog2(NUM_GAMES).
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `btn_pulse`, in, 5: single-cycle press pulses. Bit mapping:
  - [0] up
  - [1] down
  - [2] left
  - [3] right
  - [4] center
- `btn_level`, in, 5: debounced held levels, same bit mapping.
- `sel_idx`, out, IDX_W: currently selected game.
- `game_active`, out, 1: high while in PLAY.
- `game_start`, out, 1: one-cycle pulse on entry to PLAY.
- `game_exit`, out, 1: one-cycle pulse on a hold-exit from PLAY.
- `game_btn_pulse`, out, 5: button pulses forwarded to the active game.
- `game_btn_level`, out, 5: button levels forwarded to the active game.

## Operation
- **States:**
  - MENU is the reset state.
  - PLAY is the only other state.
  - There is no other state.
- **MENU, manual steps:**
  - An up pulse gives `sel_idx` = (sel==0) ? NUM_GAMES-1 : sel-1.
  - A down pulse gives `sel_idx` = (sel==NUM_GAMES-1) ? 0 : sel+1.
  - Up and down pulses in the same cycle: no step.
- **MENU, auto-repeat:**
  - It is armed only by an up or down pulse in MENU.
  - While that same direction's level stays high and the opposite level stays low, repeat steps occur at T+REPEAT_DELAY, then every REPEAT_RATE cycles after that, where T is the pulse cycle.
  - It disarms and its counter clears on:
    - release of the direction,
    - the opposite level going high,
    - a state change,
    - reset.
  - A new pulse re-arms it with T set to the new pulse cycle.
- **MENU, launch:**
  - A center pulse moves the state to PLAY.
  - Center has priority over up/down in the same cycle: no step, and the current index is launched.
  - `sel_idx` is frozen during PLAY.
- **PLAY, forwarding:**
  - `game_btn_pulse` = `btn_pulse` and `game_btn_level` = `btn_level`, both registered.
  - Exception: `game_btn_level[4]` is forced to 0 from launch until center is first seen low, so the launch press never reaches the game.
- **PLAY, exit counter:**
  - It is armed by a center pulse in PLAY and counts consecutive cycles with center level high, including the pulse cycle.
  - It clears on center release.
  - On reaching EXIT_HOLD the block returns to MENU.
- **MENU, forwarding:** all `game_btn_*` outputs are 0.
- **After exit:** a still-held center, up or down has no effect in MENU until a fresh pulse arrives.
- **Reset (any time, including mid-PLAY):**
  - state MENU, `sel_idx`=0;
  - `game_active`, `game_start`, `game_exit`, `game_btn_pulse`, `game_btn_level` all 0;
  - all counters 0, repeat disarmed, exit counter disarmed;
  - no `game_exit` pulse is generated by reset.

## Timing
- All outputs are registered. An input sampled at the edge ending cycle T is reflected in outputs during cycle T+1.
- **Step:** an up/down pulse in cycle T gives the new `sel_idx` in T+1. The same applies to repeat steps.
- **Launch:** a center pulse in T gives `game_active`=1 and `game_start`=1 in T+1. `game_start` returns to 0 in T+2.
- **Forwarding:** forwarding uses the state at the sampling cycle, so the launch-cycle pulse is never forwarded (`game_btn_pulse`=0 in T+1).
- **Exit:**
  - A center pulse at P with the level high through P+EXIT_HOLD-1 gives `game_exit`=1, `game_active`=0 and `game_btn_*`=0 in P+EXIT_HOLD.
  - `game_exit` returns to 0 the next cycle.
  - A hold of EXIT_HOLD-1 cycles does not exit.
- **Counters:** widths are sized to the parameter values. No counter may wrap: each saturates or clears at its terminal value.

## Test plan
Bench parameters for all scenarios: NUM_GAMES=3, REPEAT_DELAY=8, REPEAT_RATE=3, EXIT_HOLD=10.

1. **Reset and manual steps.** Reset, then confirm all outputs are 0. Then apply:
   - three down pulses -> `sel_idx` goes 1, 2, 0;
   - one up pulse from 0 -> `sel_idx`=2.
2. **Auto-repeat.** From `sel_idx`=0, a down pulse at T with the level held for cycles T..T+14 gives steps at T, T+8, T+11 and T+14. `sel_idx` goes 1, 2, 0, 1 and then holds after release.
3. **Simultaneous events.** Up and down pulses in the same cycle -> `sel_idx` unchanged. A center pulse together with a down pulse at `sel_idx`=1 -> PLAY with `sel_idx`=1.
4. **Launch masking.** At `sel_idx`=2, a center pulse at T with center held for 30 cycles gives:
   - `game_start`=1 and `game_active`=1 in T+1 only for `game_start`;
   - `game_btn_pulse`=0 throughout;
   - `game_btn_level[4]`=0 until release;
   - no exit.
5. **Forwarding and exit.** In PLAY:
   - a right pulse -> `game_btn_pulse[3]`=1 for one cycle, one cycle later;
   - a center hold of 9 cycles -> no exit;
   - a center pulse at P held 10 cycles -> `game_exit`=1 and `game_active`=0 in P+10, with `sel_idx` still 2.
6. **Reset mid-PLAY.** `rst` during PLAY -> next cycle has `game_active`=0, `sel_idx`=0, `game_exit`=0, and all `game_btn_*`=0.
